// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Covers load-use, decode-branch and MDU/HI-LO interlocks.
module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic [4:0]       Write_Reg_E,
    input  logic [4:0]       Write_Reg_M,
    input  logic             Reg_Write_E,
    input  logic             Mem_To_Reg_E,
    input  logic             Mem_To_Reg_M,
    input  logic             Branch_D,
    input  logic             PC_Src_D,
    input  logic             MDU_Op_D,
    input  logic             HiLo_Read_D,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             MDU_Start,
    output logic             HiLo_Write,
    output logic             MDU_Busy,
    output logic [CNT_W-1:0] Stall_Count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic             r_start;
    logic             r_hiw;
    logic             r_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_e_hit;
    logic w_m_hit;
    logic w_lw_stall;
    logic w_br_stall;
    logic w_mdu_stall;
    logic w_stall;
    logic w_accept;

    // Register 0 is hardwired, so a zero index never creates a hazard.
    assign w_e_hit = (Write_Reg_E != 5'd0) &&
                     ((Write_Reg_E == Rs_D) || (Write_Reg_E == Rt_D));
    assign w_m_hit = (Write_Reg_M != 5'd0) &&
                     ((Write_Reg_M == Rs_D) || (Write_Reg_M == Rt_D));

    assign w_lw_stall  = Mem_To_Reg_E & Reg_Write_E & w_e_hit;
    assign w_br_stall  = Branch_D &
                         ((Reg_Write_E & w_e_hit) | (Mem_To_Reg_M & w_m_hit));
    assign w_mdu_stall = (HiLo_Read_D | MDU_Op_D) & (r_state != S_IDLE);
    assign w_stall     = w_lw_stall | w_br_stall | w_mdu_stall;
    assign w_accept    = MDU_Op_D & ~w_stall & (r_state == S_IDLE);

    assign Stall_F     = w_stall;
    assign Stall_D     = w_stall;
    assign Flush_E     = w_stall;
    assign Flush_D     = PC_Src_D & ~w_stall;
    assign MDU_Start   = r_start;
    assign HiLo_Write  = r_hiw;
    assign MDU_Busy    = r_busy;
    assign Stall_Count = r_stall_cnt;

    // MDU sequencer: IDLE -> BUSY (MDU_LAT cycles) -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_start <= 1'b0;
            r_hiw   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_hiw   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_BUSY;
                        r_cnt   <= 8'(MDU_LAT - 1);
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_DONE;
                        r_hiw   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled decode cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (MDU_LAT=4, CNT_W=4).
// Vector table plus hand-built multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wre;
        logic [4:0] wrm;
        logic       rwe;
        logic       mtre;
        logic       mtrm;
        logic       br;
        logic       pcs;
        logic       mdu;
        logic       hilo;
    } in_t;

    typedef struct packed {
        logic          stall;
        logic          flushd;
        logic          start;
        logic          hiw;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs_D, Rt_D, Write_Reg_E, Write_Reg_M;
    logic          Reg_Write_E, Mem_To_Reg_E, Mem_To_Reg_M;
    logic          Branch_D, PC_Src_D, MDU_Op_D, HiLo_Read_D;
    logic          Stall_F, Stall_D, Flush_D, Flush_E;
    logic          MDU_Start, HiLo_Write, MDU_Busy;
    logic [CW-1:0] Stall_Count;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    vec_t tbl[17];

    pipeline_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs_D(Rs_D), .Rt_D(Rt_D),
        .Write_Reg_E(Write_Reg_E), .Write_Reg_M(Write_Reg_M),
        .Reg_Write_E(Reg_Write_E), .Mem_To_Reg_E(Mem_To_Reg_E),
        .Mem_To_Reg_M(Mem_To_Reg_M), .Branch_D(Branch_D),
        .PC_Src_D(PC_Src_D), .MDU_Op_D(MDU_Op_D),
        .HiLo_Read_D(HiLo_Read_D),
        .Stall_F(Stall_F), .Stall_D(Stall_D),
        .Flush_D(Flush_D), .Flush_E(Flush_E),
        .MDU_Start(MDU_Start), .HiLo_Write(HiLo_Write),
        .MDU_Busy(MDU_Busy), .Stall_Count(Stall_Count)
    );

    always #5 clk = ~clk;

    function automatic in_t mi(int rs, int rt, int wre, int wrm,
                               bit rwe, bit mtre, bit mtrm, bit br,
                               bit pcs, bit mdu, bit hilo);
        in_t x;
        x.rst  = 1'b0;
        x.rs   = 5'(rs);
        x.rt   = 5'(rt);
        x.wre  = 5'(wre);
        x.wrm  = 5'(wrm);
        x.rwe  = rwe;
        x.mtre = mtre;
        x.mtrm = mtrm;
        x.br   = br;
        x.pcs  = pcs;
        x.mdu  = mdu;
        x.hilo = hilo;
        return x;
    endfunction

    function automatic exp_t me(bit s, bit fd, bit st, bit hw, bit b, int c);
        exp_t x;
        x.stall  = s;
        x.flushd = fd;
        x.start  = st;
        x.hiw    = hw;
        x.busy   = b;
        x.cnt    = CW'(c);
        return x;
    endfunction

    task automatic drive(input in_t i);
        reset        = i.rst;
        Rs_D         = i.rs;
        Rt_D         = i.rt;
        Write_Reg_E  = i.wre;
        Write_Reg_M  = i.wrm;
        Reg_Write_E  = i.rwe;
        Mem_To_Reg_E = i.mtre;
        Mem_To_Reg_M = i.mtrm;
        Branch_D     = i.br;
        PC_Src_D     = i.pcs;
        MDU_Op_D     = i.mdu;
        HiLo_Read_D  = i.hilo;
    endtask

    task automatic compare(input string nm);
        exp_t          e;
        logic [10:0]   act;
        logic [10:0]   req;
        e   = sb_q.pop_front();
        act = {Stall_F, Stall_D, Flush_E, Flush_D,
               MDU_Start, HiLo_Write, MDU_Busy, Stall_Count};
        req = {e.stall, e.stall, e.stall, e.flushd,
               e.start, e.hiw, e.busy, e.cnt};
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {sF,sD,fE,fD,st,hw,busy,cnt}=%b req=%b",
                     nm, act, req);
        end
    endtask

    // Inputs applied just after a rising edge, outputs sampled at the falling edge.
    task automatic step(input string nm, input in_t i, input exp_t e);
        drive(i);
        sb_q.push_back(e);
        @(negedge clk);
        compare(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_t z;
        z = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset_state", z, me(0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_t z;
        z = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          rs rt wre wrm rwe mtE mtM br pcs mdu hl
        tbl[0]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mi(0, 8, 8, 0, 1, 1, 0, 0, 0, 0, 0), me(1, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mi(8, 0, 8, 0, 1, 1, 0, 0, 0, 0, 0), me(1, 0, 0, 0, 0, 1)};
        tbl[3]  = '{mi(7, 9, 8, 0, 1, 1, 0, 0, 0, 0, 0), me(0, 0, 0, 0, 0, 2)};
        tbl[4]  = '{mi(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), me(0, 0, 0, 0, 0, 2)};
        tbl[5]  = '{mi(0, 8, 8, 0, 0, 1, 0, 0, 0, 0, 0), me(0, 0, 0, 0, 0, 2)};
        tbl[6]  = '{mi(9, 0, 9, 0, 1, 0, 0, 1, 0, 0, 0), me(1, 0, 0, 0, 0, 2)};
        tbl[7]  = '{mi(9, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0), me(1, 0, 0, 0, 0, 3)};
        tbl[8]  = '{mi(9, 0, 9, 0, 1, 0, 0, 1, 1, 0, 0), me(1, 0, 0, 0, 0, 4)};
        tbl[9]  = '{mi(9, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), me(0, 1, 0, 0, 0, 5)};
        tbl[10] = '{mi(9, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0), me(0, 0, 0, 0, 0, 5)};
        tbl[11] = '{mi(9, 0, 0, 9, 0, 0, 0, 1, 0, 0, 0), me(0, 0, 0, 0, 0, 5)};
        tbl[12] = '{mi(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), me(0, 0, 0, 0, 0, 5)};
        tbl[13] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(0, 0, 0, 0, 0, 5)};
        tbl[14] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), me(0, 1, 0, 0, 0, 5)};
        tbl[15] = '{mi(0, 12, 0, 12, 0, 0, 1, 1, 1, 0, 0), me(1, 0, 0, 0, 0, 5)};
        tbl[16] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), me(0, 0, 0, 0, 0, 6)};

        do_reset();
        for (int k = 0; k < 17; k++) begin
            step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);
        end

        // Branch stalled by E, then by a load in M; flush only once clear.
        do_reset();
        step("br_e",   mi(9, 0, 9, 0, 1, 0, 0, 1, 1, 0, 0), me(1, 0, 0, 0, 0, 0));
        step("br_m",   mi(9, 0, 0, 9, 0, 0, 1, 1, 1, 0, 0), me(1, 0, 0, 0, 0, 1));
        step("br_go",  mi(9, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), me(0, 1, 0, 0, 0, 2));

        // div accepted, mfhi waits through DONE and passes in the next IDLE.
        do_reset();
        step("div_acc", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(0, 0, 0, 0, 0, 0));
        step("mfhi_c1", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(1, 0, 1, 0, 1, 0));
        step("mfhi_c2", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(1, 0, 0, 0, 1, 1));
        step("mfhi_c3", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(1, 0, 0, 0, 1, 2));
        step("mfhi_c4", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(1, 0, 0, 0, 1, 3));
        step("mfhi_c5", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(1, 0, 0, 1, 1, 4));
        step("mfhi_c6", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(0, 0, 0, 0, 0, 5));
        step("idle_c7", z, me(0, 0, 0, 0, 0, 5));

        // Second mult waits for IDLE, then starts one cycle after acceptance.
        do_reset();
        step("mul1",    mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(0, 0, 0, 0, 0, 0));
        step("mul2_c1", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(1, 0, 1, 0, 1, 0));
        step("mul2_c2", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(1, 0, 0, 0, 1, 1));
        step("mul2_c3", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(1, 0, 0, 0, 1, 2));
        step("mul2_c4", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(1, 0, 0, 0, 1, 3));
        step("mul2_c5", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(1, 0, 0, 1, 1, 4));
        step("mul2_acc", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(0, 0, 0, 0, 0, 5));
        step("mul2_st", z, me(0, 0, 1, 0, 1, 5));
        step("mul2_b2", z, me(0, 0, 0, 0, 1, 5));
        step("mul2_b3", z, me(0, 0, 0, 0, 1, 5));
        step("mul2_b4", z, me(0, 0, 0, 0, 1, 5));
        step("mul2_dn", z, me(0, 0, 0, 1, 1, 5));
        step("mul2_id", z, me(0, 0, 0, 0, 0, 5));

        // MDU op blocked by a load-use stall is retried; overlapping stalls count once.
        do_reset();
        step("mdu_lw",  mi(0, 8, 8, 0, 1, 1, 0, 0, 0, 1, 0), me(1, 0, 0, 0, 0, 0));
        step("mdu_rt",  mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(0, 0, 0, 0, 0, 1));
        step("lw_mdu",  mi(0, 8, 8, 0, 1, 1, 0, 0, 0, 0, 1), me(1, 0, 1, 0, 1, 1));
        step("once",    z, me(0, 0, 0, 0, 1, 2));

        // Reset in the second BUSY cycle aborts the op with no HI/LO write.
        do_reset();
        step("t5_acc",  mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(0, 0, 0, 0, 0, 0));
        step("t5_b1",   mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(1, 0, 1, 0, 1, 0));
        begin
            in_t r;
            r = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            r.rst = 1'b1;
            step("t5_b2rst", r, me(1, 0, 0, 0, 1, 1));
        end
        step("t5_pass", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(0, 0, 0, 0, 0, 0));
        step("t5_nohw1", z, me(0, 0, 0, 0, 0, 0));
        step("t5_nohw2", z, me(0, 0, 0, 0, 0, 0));
        step("t5_nohw3", z, me(0, 0, 0, 0, 0, 0));

        // Stall counter saturates at 2^CW-1.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step($sformatf("sat%0d", k),
                 mi(5, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0),
                 me(1, 0, 0, 0, 0, (k > 15) ? 15 : k));
        end
        step("sat_hold", z, me(0, 0, 0, 0, 0, 15));
        step("zero_reg", mi(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), me(0, 0, 0, 0, 0, 15));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
